// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch PC controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  // Fixed instruction size; sequential fetch advances by this amount.
  localparam int unsigned InstrBytes = 4;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: keeps one instruction-memory request in flight,
// presents fetched instructions to decode, and squashes wrong-path data
// on branch/jump redirects.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned           WordSize    = 32,
  parameter logic [WordSize-1:0]   ResetVector = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [WordSize-1:0] redirect_addr,
  input  logic                stall,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [WordSize-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  output logic                imem_rsp_ready,
  input  logic [WordSize-1:0] imem_rsp_data,
  output logic                if_valid,
  output logic [WordSize-1:0] if_pc,
  output logic [WordSize-1:0] if_instr
);

  localparam logic [WordSize-1:0] Step      = WordSize'(InstrBytes);
  localparam logic [WordSize-1:0] AlignMask = ~(WordSize'(InstrBytes - 1));

  fetch_state_e        state_q;
  logic [WordSize-1:0] pc_q;
  logic [WordSize-1:0] req_pc_q;
  logic                if_valid_q;
  logic [WordSize-1:0] if_pc_q;
  logic [WordSize-1:0] if_instr_q;

  logic                slot_free;
  logic                req_fire;
  logic                rsp_fire;
  logic                capture;
  logic [WordSize-1:0] redirect_pc;
  logic [WordSize-1:0] next_seq_pc;

  // Handshake and datapath helpers derived from current state and inputs.
  always_comb begin
    slot_free      = !if_valid_q || !stall;
    imem_req_valid = (state_q == ST_REQ) && !redirect_valid && slot_free;
    imem_req_addr  = pc_q;
    imem_rsp_ready = ((state_q == ST_WAIT) && slot_free) || (state_q == ST_DROP);
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_fire       = imem_rsp_valid && imem_rsp_ready;
    capture        = (state_q == ST_WAIT) && rsp_fire && !redirect_valid;
    redirect_pc    = redirect_addr & AlignMask;
    next_seq_pc    = req_pc_q + Step;
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  // Fetch FSM, PC registers and the decode-facing output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= ResetVector;
      req_pc_q   <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      if (redirect_valid) begin
        if_valid_q <= 1'b0;
      end else if (capture) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= req_pc_q;
        if_instr_q <= imem_rsp_data;
      end else if (slot_free) begin
        if_valid_q <= 1'b0;
      end

      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (req_fire) begin
            req_pc_q <= pc_q;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            state_q <= rsp_fire ? ST_REQ : ST_DROP;
          end else if (rsp_fire) begin
            pc_q    <= next_seq_pc;
            state_q <= ST_REQ;
          end
        end
        ST_DROP: begin
          // The stale response is consumed even when a further redirect
          // lands in the same cycle; waiting for another would deadlock.
          if (rsp_fire) begin
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl with a variable-latency memory model.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_pc_ctrl #(.WordSize(32), .ResetVector(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  // Memory model: one outstanding request, response after lat cycles.
  int unsigned lat = 1;
  logic        pend;
  logic [31:0] pend_addr;
  int unsigned pend_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_cnt  <= 0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend      <= 1'b1;
      pend_addr <= imem_req_addr;
      pend_cnt  <= lat;
    end else if (pend) begin
      if (imem_rsp_valid && imem_rsp_ready) pend <= 1'b0;
      else if (pend_cnt > 1) pend_cnt <= pend_cnt - 1;
    end
  end

  assign imem_rsp_valid = pend && (pend_cnt == 1);
  assign imem_rsp_data  = mem_data(pend_addr);

  // Scoreboards: expected request addresses and expected decode PCs.
  logic [31:0] exp_req[$];
  logic [31:0] exp_if[$];

  int          cyc = 0;
  int          req_cnt = 0;
  int          last_req_cyc = 0;
  bit          lat_chk = 1'b0;
  bit          held = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  // Monitor: samples just before each rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", {31'b0, if_valid}, 32'd1);
          chk("hold_pc", if_pc, hold_pc);
          chk("hold_instr", if_instr, hold_instr);
          if (stall) begin
            chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("hold_rsp_rdy", {31'b0, imem_rsp_ready}, 32'd0);
          end
        end else if (if_valid) begin
          if (exp_if.size() > 0) begin
            logic [31:0] e;
            e = exp_if.pop_front();
            chk("if_pc", if_pc, e);
            chk("if_instr", if_instr, mem_data(e));
            if (lat_chk) chk("if_latency", cyc - last_req_cyc, 32'd2);
          end else begin
            chk("if_unexpected", if_pc, 32'hxxxx_xxxx);
          end
          hold_pc    = if_pc;
          hold_instr = if_instr;
        end
        if (imem_req_valid && imem_req_ready) begin
          req_cnt++;
          last_req_cyc = cyc;
          if (exp_req.size() > 0) chk("req_addr", imem_req_addr, exp_req.pop_front());
          else chk("req_unexpected", imem_req_addr, 32'hxxxx_xxxx);
        end
        held = if_valid && stall && !redirect_valid;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int  target;
    bit  done;
    target = req_cnt + n;
    done   = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1);
      if (req_cnt >= target) done = 1'b1;
    end
    if (!done) chk("req_timeout", req_cnt, target);
  endtask

  task automatic rst_pulse();
    chk("req_q_empty", exp_req.size(), 32'd0);
    chk("if_q_empty", exp_if.size(), 32'd0);
    exp_req.delete();
    exp_if.delete();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    tick(2);
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    tick(2);

    // Reset state
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_pc", imem_req_addr, 32'd0);

    // Sequential fetch with 1-cycle responses
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_if  = '{32'h0, 32'h4, 32'h8};
    lat_chk = 1'b1;
    rst = 1'b0;
    wait_reqs(3, 40);
    imem_req_ready = 1'b0;
    tick(4);
    lat_chk = 1'b0;

    // Backpressure holds the slot and blocks new requests
    rst_pulse();
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_if  = '{32'h0, 32'h4, 32'h8};
    imem_req_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(2, 40);
    stall = 1'b1;
    tick(4);
    stall = 1'b0;
    wait_reqs(1, 20);
    imem_req_ready = 1'b0;
    tick(4);

    // Redirect while waiting: in-flight response dropped
    rst_pulse();
    lat = 3;
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_if  = '{32'h0, 32'h4, 32'h100};
    imem_req_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(3, 60);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_if_clr", {31'b0, if_valid}, 32'd0);
    wait_reqs(1, 40);
    imem_req_ready = 1'b0;
    tick(8);

    // Redirect coincident with response, unaligned target
    rst_pulse();
    lat = 1;
    exp_req = '{32'h0, 32'h200};
    exp_if  = '{32'h200};
    imem_req_ready = 1'b1;
    rst = 1'b0;
    wait_reqs(1, 20);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h203;
    chk("coinc_rsp_fire", {31'b0, imem_rsp_valid & imem_rsp_ready}, 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    chk("coinc_if_clr", {31'b0, if_valid}, 32'd0);
    wait_reqs(1, 20);
    imem_req_ready = 1'b0;
    tick(4);

    // PC wraps at the top of the address space
    rst_pulse();
    exp_req = '{32'hFFFF_FFFC, 32'h0};
    exp_if  = '{32'hFFFF_FFFC, 32'h0};
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFF;
    rst = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    wait_reqs(2, 30);
    imem_req_ready = 1'b0;
    tick(4);

    // Asynchronous reset in the middle of a fetch
    rst_pulse();
    lat = 3;
    exp_req = '{32'h40, 32'h44};
    exp_if  = '{32'h40};
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    rst = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    wait_reqs(2, 40);
    chk("pre_rst_if_pc", if_pc, 32'h40);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
    chk("mid_rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'd0);
    chk("mid_rst_if_instr", if_instr, 32'd0);
    tick(2);
    lat = 1;
    exp_req = '{32'h0};
    exp_if  = '{32'h0};
    rst = 1'b0;
    wait_reqs(1, 20);
    imem_req_ready = 1'b0;
    tick(4);

    chk("final_req_q", exp_req.size(), 32'd0);
    chk("final_if_q", exp_if.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
